// File: rtl/hist_readout_seq_if.sv
// Valid/ready byte link from the histogram readout sequencer toward the slow-control TX.
interface hist_readout_seq_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (output tx_data, output tx_valid, input tx_ready);
    modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/hist_readout_seq.sv
// Steps the histogram bin selector, captures NCH 32-bit counters per bin and streams them
// as a header/data/XOR-checksum byte frame over a valid/ready link.
module hist_readout_seq #(
    parameter int         NCH        = 8,
    parameter int         NBINS      = 16,
    parameter int         SETTLE_CYC = 4,
    parameter logic [7:0] HDR        = 8'h5A
) (
    input  logic                clk,
    input  logic                nrst,
    input  logic                start,
    input  logic [NCH*32-1:0]   hist_in,
    output logic [7:0]          bin_sel,
    output logic                busy,
    output logic                done,
    hist_readout_seq_if.master  tx
);
    localparam int NBYTES = NCH * 4;
    localparam int IW     = $clog2(NBYTES);
    localparam int CW     = $clog2(SETTLE_CYC + 1);

    typedef enum logic [2:0] {IDLE, HDRS, SETTLE, CAPT, SEND, CHKS} state_e;

    state_e              state_q, state_d;
    logic [7:0]          bin_sel_q, bin_sel_d;
    logic [7:0]          tx_data_q, tx_data_d;
    logic                tx_valid_q, tx_valid_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [7:0]          chk_q, chk_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic [NCH*32-1:0]   shadow_q, shadow_d;
    logic                accept;

    // Byte idx of the captured words: lane idx/4, most significant byte of each lane first.
    function automatic logic [7:0] pick_byte(input logic [NCH*32-1:0] w, input logic [IW-1:0] idx);
        logic [IW+2:0] off;
        off = {idx[IW-1:2], ~idx[1:0], 3'b000};
        return w[off +: 8];
    endfunction

    assign accept = tx_valid_q & tx.tx_ready;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latches).
        state_d    = state_q;
        bin_sel_d  = bin_sel_q;
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        chk_d      = chk_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        shadow_d   = shadow_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = HDRS;
                    busy_d     = 1'b1;
                    bin_sel_d  = 8'd0;
                    chk_d      = 8'd0;
                    tx_valid_d = 1'b1;
                    tx_data_d  = HDR;
                end
            end
            HDRS: begin
                if (accept) begin
                    state_d    = SETTLE;
                    tx_valid_d = 1'b0;
                    cnt_d      = CW'(SETTLE_CYC);
                end
            end
            SETTLE: begin
                if (cnt_q == CW'(1)) state_d = CAPT;
                else                 cnt_d   = cnt_q - CW'(1);
            end
            CAPT: begin
                shadow_d   = hist_in;
                idx_d      = '0;
                state_d    = SEND;
                tx_valid_d = 1'b1;
                tx_data_d  = pick_byte(hist_in, '0);
            end
            SEND: begin
                if (accept) begin
                    chk_d = chk_q ^ tx_data_q;
                    if (idx_q == IW'(NBYTES - 1)) begin
                        if (bin_sel_q == 8'(NBINS - 1)) begin
                            state_d   = CHKS;
                            tx_data_d = chk_q ^ tx_data_q;
                        end else begin
                            state_d    = SETTLE;
                            tx_valid_d = 1'b0;
                            bin_sel_d  = bin_sel_q + 8'd1;
                            cnt_d      = CW'(SETTLE_CYC);
                        end
                    end else begin
                        idx_d     = idx_q + IW'(1);
                        tx_data_d = pick_byte(shadow_q, idx_q + IW'(1));
                    end
                end
            end
            CHKS: begin
                if (accept) begin
                    state_d    = IDLE;
                    tx_valid_d = 1'b0;
                    busy_d     = 1'b0;
                    done_d     = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q    <= IDLE;
            bin_sel_q  <= 8'd0;
            tx_data_q  <= 8'd0;
            tx_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            chk_q      <= 8'd0;
            cnt_q      <= '0;
            idx_q      <= '0;
        end else begin
            state_q    <= state_d;
            bin_sel_q  <= bin_sel_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            chk_q      <= chk_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
        end
    end

    // NOTE: the wide capture register is always written in CAPT before it is read, so it needs no reset.
    always_ff @(posedge clk) begin
        shadow_q <= shadow_d;
    end

    assign bin_sel     = bin_sel_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign tx.tx_data  = tx_data_q;
    assign tx.tx_valid = tx_valid_q;
endmodule

// File: tb/tb_hist_readout_seq.sv
// Scoreboard bench for hist_readout_seq: directed frames with hand-derived patterns and checksums.
`timescale 1ns/1ps
module tb_hist_readout_seq;
    localparam int         NCH   = 8;
    localparam int         NBINS = 16;
    localparam logic [7:0] HDR   = 8'h5A;
    localparam int         FRAME = 2 + NBINS * NCH * 4;

    typedef struct {
        logic [7:0] data;
        bit         last;
    } exp_t;

    logic clk = 1'b0;
    logic nrst = 1'b0;
    logic start = 1'b0;
    logic start2 = 1'b0;
    logic [7:0] bin_sel, bin_sel2;
    logic busy, done, busy2, done2;
    logic [NCH*32-1:0] hist_in, hist_in2;
    logic [7:0] lag [3];
    logic [7:0] lag2 [3];

    int  mode = 0;
    bit  use_lag = 1'b0;
    bit  bp = 1'b0;
    int  n_checks = 0;
    int  n_errors = 0;
    int  bytes_seen = 0;
    int  done_cnt = 0;
    logic [7:0] last_byte = 8'h00;
    exp_t exp_q[$];

    hist_readout_seq_if link ();
    hist_readout_seq_if link2 ();

    always #5 clk = ~clk;

    hist_readout_seq #(.NCH(NCH), .NBINS(NBINS), .SETTLE_CYC(4), .HDR(HDR)) dut (
        .clk(clk), .nrst(nrst), .start(start), .hist_in(hist_in),
        .bin_sel(bin_sel), .busy(busy), .done(done), .tx(link)
    );

    hist_readout_seq #(.NCH(NCH), .NBINS(NBINS), .SETTLE_CYC(2), .HDR(HDR)) dut2 (
        .clk(clk), .nrst(nrst), .start(start2), .hist_in(hist_in2),
        .bin_sel(bin_sel2), .busy(busy2), .done(done2), .tx(link2)
    );

    // Producer model: histosout follows the bin selector three cycles late.
    always @(posedge clk) begin
        lag[0] <= bin_sel;   lag[1] <= lag[0];   lag[2] <= lag[1];
        lag2[0] <= bin_sel2; lag2[1] <= lag2[0]; lag2[2] <= lag2[1];
    end

    function automatic logic [31:0] lane_word(input int m, input logic [7:0] bin, input int k);
        case (m)
            0:       return {bin, 8'h00, 8'(k), 8'hC3};
            1:       return {8'(int'(bin) * 8 + k + 1), 8'hF0, 8'h0F, 8'(k)};
            default: return 32'hFFFF_FFFF;
        endcase
    endfunction

    function automatic logic [NCH*32-1:0] build(input int m, input logic [7:0] bin);
        logic [NCH*32-1:0] h;
        for (int k = 0; k < NCH; k++) h[32*k +: 32] = lane_word(m, bin, k);
        return h;
    endfunction

    function automatic logic [7:0] data_byte(input int m, input int n);
        logic [31:0] w;
        w = lane_word(m, 8'(n / 32), (n % 32) / 4);
        return 8'(w >> (8 * (3 - n % 4)));
    endfunction

    assign hist_in  = build(mode, use_lag ? lag[2] : bin_sel);
    assign hist_in2 = build(1, lag2[2]);

    initial begin
        link.tx_ready  = 1'b1;
        link2.tx_ready = 1'b1;
    end

    always @(posedge clk) begin
        #1;
        link.tx_ready = bp ? ($urandom_range(0, 9) < 3) : 1'b1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic push_frame(input int m);
        exp_t e;
        logic [7:0] chk;
        chk = 8'h00;
        e.last = 1'b0;
        e.data = HDR;
        exp_q.push_back(e);
        for (int n = 0; n < FRAME - 2; n++) begin
            e.data = data_byte(m, n);
            chk ^= e.data;
            exp_q.push_back(e);
        end
        e.data = chk;
        e.last = 1'b1;
        exp_q.push_back(e);
    endtask

    // Monitor: pops the scoreboard on every accepted byte and checks handshake stability and done timing.
    bit         done_expect = 1'b0;
    bit         hold_pending = 1'b0;
    logic [7:0] held_data = 8'h00;
    always @(negedge clk) begin
        if (!nrst) begin
            done_expect  = 1'b0;
            hold_pending = 1'b0;
        end else begin
            if (done) done_cnt++;
            if (done_expect) begin
                check("done_pulse", done, 1);
                done_expect = 1'b0;
            end else if (done) begin
                check("done_spurious", done, 0);
            end
            if (hold_pending) begin
                check("hold_valid", link.tx_valid, 1);
                check("hold_data", link.tx_data, held_data);
            end
            hold_pending = link.tx_valid && !link.tx_ready;
            held_data    = link.tx_data;
            if (link.tx_valid && link.tx_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_byte: got %0h, expected no byte", link.tx_data);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("byte", link.tx_data, e.data);
                    bytes_seen++;
                    last_byte = link.tx_data;
                    if (e.last) done_expect = 1'b1;
                end
            end
        end
    end

    task automatic do_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic wait_done(input int limit, output int n);
        n = 0;
        while (!done && n < limit) begin
            @(posedge clk); #1;
            n++;
        end
        if (!done) check("done_timeout", done, 1);
    endtask

    task automatic wait_bin(input logic [7:0] b, input int limit);
        int n = 0;
        while (!(bin_sel == b && link.tx_valid) && n < limit) begin
            @(posedge clk); #1;
            n++;
        end
        check("reach_bin", bin_sel, b);
    endtask

    task automatic run_frame(input int m, input int limit, input logic [7:0] exp_chk, output int cyc);
        int b0;
        b0 = bytes_seen;
        push_frame(m);
        do_start();
        check("busy_after_start", busy, 1);
        wait_done(limit, cyc);
        @(posedge clk); #1;
        check("frame_bytes", bytes_seen - b0, FRAME);
        check("chk_byte", last_byte, exp_chk);
        check("busy_after_done", busy, 0);
        check("scoreboard_empty", exp_q.size(), 0);
    endtask

    initial begin
        int cyc, d0, nb, mism;
        #1;
        check("rst_bin_sel", bin_sel, 0);
        check("rst_tx_valid", link.tx_valid, 0);
        check("rst_tx_data", link.tx_data, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        #12 nrst = 1'b1;

        // Nominal frame, tx_ready held high: checksum of this pattern is 0x00.
        run_frame(0, 2000, 8'h00, cyc);
        check("frame_cycles", cyc, 1 + NBINS * (4 + 1 + NCH * 4) + 1);

        // Backpressure with roughly 30% ready duty.
        bp = 1'b1;
        run_frame(0, 8000, 8'h00, cyc);
        bp = 1'b0;

        // Lagging producer with SETTLE_CYC=4: all bins must be correct; checksum 0x80.
        use_lag = 1'b1;
        mode = 1;
        run_frame(1, 2000, 8'h80, cyc);

        // Same lag with SETTLE_CYC=2 captures stale words.
        @(posedge clk); #1 start2 = 1'b1;
        @(posedge clk); #1 start2 = 1'b0;
        nb = 0;
        mism = 0;
        for (int i = 0; i < 2000 && nb < FRAME; i++) begin
            @(negedge clk);
            if (link2.tx_valid) begin
                if (nb >= 1 && nb <= FRAME - 2 && link2.tx_data !== data_byte(1, nb - 1)) mism++;
                nb++;
            end
        end
        check("short_settle_bytes", nb, FRAME);
        check("short_settle_detects_lag", mism > 0, 1);
        use_lag = 1'b0;
        repeat (4) @(posedge clk);

        // start during bin 5 and on the checksum accept cycle must be ignored.
        mode = 0;
        d0 = done_cnt;
        push_frame(0);
        do_start();
        wait_bin(8'd5, 1000);
        start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        cyc = 0;
        while (exp_q.size() != 1 && cyc < 2000) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("reach_chk", exp_q.size(), 1);
        start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        wait_done(10, cyc);
        repeat (20) @(posedge clk);
        #1;
        check("one_done_pulse", done_cnt - d0, 1);
        check("no_second_frame", busy, 0);

        // Reset during bin 7 SEND, then a clean frame with a fresh checksum.
        mode = 1;
        d0 = done_cnt;
        push_frame(1);
        do_start();
        wait_bin(8'd7, 1000);
        #2 nrst = 1'b0;
        #1;
        check("midrst_tx_valid", link.tx_valid, 0);
        check("midrst_busy", busy, 0);
        check("midrst_bin_sel", bin_sel, 0);
        exp_q.delete();
        @(negedge clk); #1 nrst = 1'b1;
        repeat (3) @(posedge clk);
        check("midrst_no_done", done_cnt - d0, 0);
        run_frame(1, 2000, 8'h80, cyc);

        // All-ones counters: 512 bytes of 0xFF, checksum 0x00.
        mode = 2;
        run_frame(2, 2000, 8'h00, cyc);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
